// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the register file core.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, with same-cycle writeback masking on lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] look1,
  input  logic [ADDR_W-1:0] look2,
  output logic              hit1,
  output logic              hit2
);

  logic [NUM_REGS-1:0] busy;

  // Busy bits: set after clear so a same-cycle claim beats the writeback.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  // Lookups hide a pending bit whose writeback is on the port this cycle.
  always_comb begin
    hit1 = busy[look1] & ~(clr_en & (clr_idx == look1));
    hit2 = busy[look2] & ~(clr_en & (clr_idx == look2));
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with writeback bypass, pending-write scoreboard and a
// one-entry-per-cycle clear engine (runs after reset and on request).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam logic HAS_ZERO = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              idle;
  logic              wr_en;
  logic              iss_en;
  logic              flush;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              hit1, hit2;

  // Qualify the external ports: only live in IDLE out of reset, r0 filtered.
  always_comb begin
    idle   = rst_n && (state == IDLE);
    wr_en  = idle && we    && !(HAS_ZERO && (waddr    == '0));
    iss_en = idle && issue && !(HAS_ZERO && (issue_rd == '0));
    flush  = idle && clr_req;
  end

  // Clear FSM state and pointer; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  // Next state, clear pointer and array write-port selection.
  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    mem_we     = 1'b0;
    mem_addr   = waddr;
    mem_data   = wdata;
    unique case (state)
      IDLE: begin
        mem_we = wr_en;
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end
      end
      CLEAR: begin
        mem_we     = rst_n;
        mem_addr   = clr_ptr;
        mem_data   = '0;
        clr_ptr_nx = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST) state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Register array, no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .set_en  (iss_en),
    .set_idx (issue_rd),
    .clr_en  (wr_en),
    .clr_idx (waddr),
    .look1   (raddr1),
    .look2   (raddr2),
    .hit1    (hit1),
    .hit2    (hit2)
  );

  // Read ports: blocked outputs during clear/reset, then r0, bypass, array.
  always_comb begin
    clr_busy = !idle;
    if (!idle) begin
      rdata1 = '0;
      rdata2 = '0;
      busy1  = 1'b1;
      busy2  = 1'b1;
    end else begin
      if (HAS_ZERO && (raddr1 == '0))      rdata1 = '0;
      else if (wr_en && (waddr == raddr1)) rdata1 = wdata;
      else                                 rdata1 = mem[raddr1];
      if (HAS_ZERO && (raddr2 == '0))      rdata2 = '0;
      else if (wr_en && (waddr == raddr2)) rdata2 = wdata;
      else                                 rdata2 = mem[raddr2];
      busy1 = hit1 && !(HAS_ZERO && (raddr1 == '0));
      busy2 = hit2 && !(HAS_ZERO && (raddr2 == '0));
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with hand-computed expected values.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        issue;
  logic [2:0]  issue_rd;
  logic [2:0]  raddr1, raddr2;
  logic [15:0] rdata1, rdata2;
  logic        busy1, busy2;
  logic        clr_req;
  logic        clr_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc;

  regfile_sb #(
    .DATA_W   (16),
    .NUM_REGS (8),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .issue    (issue),
    .issue_rd (issue_rd),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .busy1    (busy1),
    .busy2    (busy2),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive cycles with clr_busy high, bounded at 20.
  task automatic count_clear(output int n);
    n = 0;
    #1;
    while (clr_busy === 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    issue = 1'b0; issue_rd = '0; raddr1 = 3'd1; raddr2 = 3'd2; clr_req = 1'b0;

    // Reset state
    step(); step(); step();
    we = 1'b1; waddr = 3'd1; wdata = 16'h7777;
    #1;
    check("rst_clr_busy", 32'(clr_busy), 32'd1);
    check("rst_busy1",    32'(busy1),    32'd1);
    check("rst_busy2",    32'(busy2),    32'd1);
    check("rst_rdata1",   32'(rdata1),   32'h0);
    we = 1'b0;

    // Reset release: exactly 8 clear cycles
    step();
    rst_n = 1'b1;
    count_clear(ncyc);
    check("rst_clear_len", 32'(ncyc), 32'd8);

    for (int i = 1; i < 8; i++) begin
      raddr1 = 3'(i); raddr2 = 3'(i);
      #1;
      check($sformatf("post_rst_rd_r%0d", i), 32'(rdata1), 32'h0);
      check($sformatf("post_rst_busy_r%0d", i), 32'(busy2), 32'd0);
    end

    // Write/read r3
    step();
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    step();
    we = 1'b0; raddr1 = 3'd3;
    #1;
    check("wr_r3", 32'(rdata1), 32'hBEEF);

    // r0 is hardwired zero
    we = 1'b1; waddr = 3'd0; wdata = 16'h1234; raddr1 = 3'd0;
    #1;
    check("r0_byp_rd", 32'(rdata1), 32'h0);
    check("r0_byp_busy", 32'(busy1), 32'd0);
    step();
    we = 1'b0;
    #1;
    check("r0_rd", 32'(rdata1), 32'h0);

    // Bypass
    we = 1'b1; waddr = 3'd5; wdata = 16'hA5A5; raddr1 = 3'd5; raddr2 = 3'd3;
    #1;
    check("byp_rd1", 32'(rdata1), 32'hA5A5);
    check("byp_busy1", 32'(busy1), 32'd0);
    check("byp_rd2_other", 32'(rdata2), 32'hBEEF);
    step();
    we = 1'b0;
    #1;
    check("byp_stored", 32'(rdata1), 32'hA5A5);

    // Scoreboard: issue then writeback three cycles later
    issue = 1'b1; issue_rd = 3'd2;
    step();
    issue = 1'b0; raddr1 = 3'd2;
    #1;
    check("sb_busy_set", 32'(busy1), 32'd1);
    step(); step();
    we = 1'b1; waddr = 3'd2; wdata = 16'h0222;
    #1;
    check("sb_wb_mask", 32'(busy1), 32'd0);
    check("sb_wb_byp", 32'(rdata1), 32'h0222);
    step();
    we = 1'b0;
    #1;
    check("sb_busy_clr", 32'(busy1), 32'd0);
    check("sb_rd", 32'(rdata1), 32'h0222);

    // Same-cycle issue and writeback: claim wins
    issue = 1'b1; issue_rd = 3'd2; we = 1'b1; waddr = 3'd2; wdata = 16'h3333;
    step();
    issue = 1'b0; we = 1'b0;
    #1;
    check("sb_same_busy", 32'(busy1), 32'd1);
    check("sb_same_data", 32'(rdata1), 32'h3333);
    we = 1'b1; waddr = 3'd2; wdata = 16'h0202;
    step();
    we = 1'b0;
    #1;
    check("sb_release", 32'(busy1), 32'd0);

    // Issue to r0 ignored
    issue = 1'b1; issue_rd = 3'd0;
    step();
    issue = 1'b0; raddr1 = 3'd0;
    #1;
    check("r0_issue_busy", 32'(busy1), 32'd0);

    // Fill r1..r7, then clear request
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
      step();
    end
    we = 1'b0; issue = 1'b1; issue_rd = 3'd6; raddr1 = 3'd7; raddr2 = 3'd6;
    #1;
    check("fill_r7", 32'(rdata1), 32'h1007);
    step();
    issue = 1'b0;
    #1;
    check("fill_busy_r6", 32'(busy2), 32'd1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 1'b1; waddr = 3'd6; wdata = 16'hFFFF; issue = 1'b1; issue_rd = 3'd4;
    raddr1 = 3'd1; raddr2 = 3'd7;
    #1;
    check("clr_rd1", 32'(rdata1), 32'h0);
    check("clr_busy1", 32'(busy1), 32'd1);
    check("clr_busy2", 32'(busy2), 32'd1);
    count_clear(ncyc);
    we = 1'b0; issue = 1'b0;
    check("clr_len", 32'(ncyc), 32'd8);
    for (int i = 1; i < 8; i++) begin
      raddr1 = 3'(i); raddr2 = 3'(i);
      #1;
      check($sformatf("post_clr_rd_r%0d", i), 32'(rdata1), 32'h0);
      check($sformatf("post_clr_busy_r%0d", i), 32'(busy2), 32'd0);
    end

    // Reset mid-clear restarts a full clear
    step();
    we = 1'b1; waddr = 3'd3; wdata = 16'h3333;
    step();
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("midrst_clr_busy", 32'(clr_busy), 32'd1);
    check("midrst_busy1", 32'(busy1), 32'd1);
    step();
    rst_n = 1'b1;
    count_clear(ncyc);
    check("midrst_clr_len", 32'(ncyc), 32'd8);
    raddr1 = 3'd3;
    #1;
    check("midrst_r3", 32'(rdata1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
